multi_timer: RTL
================

Name: multi_timer

Overview:
Parametrised multi-channel successor to the single-shot threshold counter. A shared prescaler produces a count strobe. CHANNELS independent timers count that strobe up to a per-channel threshold, in one-shot or periodic mode, with explicit start/stop control. Instantiated wherever the LED/microcode sequencer needs several concurrent delays or blink rates from one clock.

Parameters:
WIDTH, 10, bit width of each channel counter and threshold
CHANNELS, 4, number of independent timer channels (>=1)
PRE_WIDTH, 8, bit width of the shared prescaler

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
en  in  1  global enable; when 0, prescaler and all channel counters freeze
prescale  in  PRE_WIDTH  strobe every prescale+1 enabled cycles
start  in  CHANNELS  per-channel start/restart pulse
stop  in  CHANNELS  per-channel abort pulse
periodic  in  CHANNELS  mode, sampled at start: 1 = auto-reload, 0 = one-shot
threshold  in  CHANNELS*WIDTH  flat; channel i in bits [i*WIDTH +: WIDTH], sampled at start
running  out  CHANNELS  channel i is in RUN
finished  out  CHANNELS  one-shot complete; level, held until the next start or stop
tick  out  CHANNELS  one-cycle pulse at each expiry, both modes
count  out  CHANNELS*WIDTH  flat live counter values

Behaviour:
- Reset (reset_n=0 at clk edge): prescaler counter=0, strobe=0, every channel IDLE, ctr=0, latched threshold=0, running/finished/tick=0. Reset overrides all other inputs. Reset mid-count aborts with no tick.
- Prescaler:
  - Only advances when en=1.
  - If pre_ctr >= prescale: pre_ctr<=0 and the internal strobe stb is 1 for that cycle; otherwise pre_ctr<=pre_ctr+1 and stb=0.
  - stb is combinational from pre_ctr, prescale and en.
  - prescale=0 gives stb on every enabled cycle.
  - Lowering prescale below pre_ctr wraps on the next enabled cycle.
  - The prescaler is free-running and shared. Start does not reset it, so first-period jitter is up to prescale cycles by design.
- Channel FSM (states IDLE, RUN, DONE), priority stop > start > count:
  - stop[i]=1 (any state): go IDLE; ctr<=0; finished<=0; tick<=0.
  - start[i]=1 (any state, stop low): latch threshold and periodic; ctr<=0; finished<=0; go RUN. Restart in RUN discards progress.
  - start/stop act regardless of en.
  - RUN, stb=1, ctr >= thr_q:
    - tick<=1 next cycle.
    - periodic: ctr<=0, stay RUN.
    - one-shot: finished<=1, go DONE, ctr holds its value.
  - RUN, stb=1, ctr < thr_q: ctr<=ctr+1.
  - RUN, stb=0: hold.
  - DONE: hold; finished=1 until start or stop.
- Timing:
  - Expiry occurs on the stb on which ctr equals thr_q, i.e. after thr_q+1 strobes from start.
  - threshold=0 expires on the first strobe.
  - tick and finished appear the cycle after that strobe cycle.
- tick is exactly one cycle per expiry. A periodic channel with prescale=0, threshold=0 ticks every enabled cycle, so tick stays high continuously.
- running=1 exactly when the state is RUN.
- Counter arithmetic is unsigned WIDTH bits. ctr never exceeds thr_q, so there is no wrap. The maximum threshold 2^WIDTH-1 is legal.
- Channels are fully independent apart from sharing stb. Simultaneous expiry on several channels raises several tick bits in the same cycle.
- en=0 mid-run: the counter freezes and resumes exactly on en=1. No expiry is lost.

Test Plan:
1. Reset release, prescale=0, en=1; ch0 start with threshold=5, one-shot -> tick[0] and finished[0] rise 6 cycles after the start edge; finished holds, running[0]=0, count0=5.
2. prescale=3, ch1 start with threshold=2, periodic -> tick[1] is a 1-cycle pulse every 12 cycles, repeated 4 times, finished[1] stays 0; then stop[1] -> running=0, count1=0, no further ticks.
3. ch0 start threshold=0 and ch2 start threshold=0 in the same cycle, prescale=0 -> both tick bits high in the same cycle, 1 cycle after start.
4. ch0 running threshold=10, count=7: pulse start and stop together -> IDLE, count=0, no tick. Then restart at count=7 with threshold=3 -> expiry after 4 further strobes.
5. ch3 periodic threshold=4, prescale=0; drop en for 5 cycles at count=2 -> count holds 2, tick delayed by exactly 5 cycles. Assert reset_n=0 for 1 cycle mid-run -> all outputs 0, channel IDLE.
6. WIDTH=4 instance, threshold=15 one-shot, prescale=0 -> finished after 16 strobes, count=15, no wrap to 0.

Source files
------------

// File: rtl/multi_timer.sv
`default_nettype none
// multi_timer: shared prescaler strobe driving CHANNELS independent one-shot/periodic
// threshold timers with start/stop control.
module multi_timer #(
  parameter int WIDTH     = 10,
  parameter int CHANNELS  = 4,
  parameter int PRE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [PRE_WIDTH-1:0]      prescale,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] threshold,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       finished,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [PRE_WIDTH-1:0] pre_ctr;
  logic                 stb;

  // Free-running; a start never resynchronises it.
  assign stb = en && (pre_ctr >= prescale);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_ctr <= '0;
    end else if (en) begin
      if (stb) begin
        pre_ctr <= '0;
      end else begin
        pre_ctr <= pre_ctr + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t             state;
    logic [WIDTH-1:0]   ctr;
    logic [WIDTH-1:0]   thr_q;
    logic               per_q;
    logic               fin_q;
    logic               tick_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state  <= IDLE;
        ctr    <= '0;
        thr_q  <= '0;
        per_q  <= 1'b0;
        fin_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (stop[i]) begin
          state <= IDLE;
          ctr   <= '0;
          fin_q <= 1'b0;
        end else if (start[i]) begin
          state <= RUN;
          ctr   <= '0;
          fin_q <= 1'b0;
          thr_q <= threshold[i*WIDTH +: WIDTH];
          per_q <= periodic[i];
        end else if (state == RUN && stb) begin
          // ctr never passes thr_q, so the maximum threshold cannot wrap.
          if (ctr >= thr_q) begin
            tick_q <= 1'b1;
            if (per_q) begin
              ctr <= '0;
            end else begin
              fin_q <= 1'b1;
              state <= DONE;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
      end
    end

    assign running[i]                = (state == RUN);
    assign finished[i]               = fin_q;
    assign tick[i]                   = tick_q;
    assign count[i*WIDTH +: WIDTH]   = ctr;
  end

endmodule
`default_nettype wire
